tt_sweep_eval: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_lut_mux.sv | 14 +
 rtl/tt_sweep_eval.sv | 179 +++++++++++++++++
 tb/tb_tt_sweep_eval.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and sizing helpers for tt_sweep_eval
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  // Truth-table width for n Boolean inputs.
  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

  // Counter width able to hold 0 .. cycles-1 (at least one bit).
  function automatic int cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/tt_lut_mux.sv
// rtl/tt_lut_mux.sv - combinational TT_W:1 truth-table bit select
module tt_lut_mux
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [tt_w(N_IN)-1:0] tt_i,
  input  logic [N_IN-1:0]       sel_i,
  output logic                  bit_o
);

  assign bit_o = tt_i[sel_i];

endmodule

// File: rtl/tt_sweep_eval.sv
// rtl/tt_sweep_eval.sv - truth-table evaluator with exhaustive netlist sweep; option macro TTS_DUT_SYNC_EN
module tt_sweep_eval
  import tt_sweep_pkg::*;
#(
  parameter int                    N_IN    = 4,
  parameter logic [tt_w(N_IN)-1:0] TT_INIT = 16'h09AF,
  parameter int                    SETTLE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tt_wr,
  input  logic [tt_w(N_IN)-1:0] tt_wdata,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic [N_IN-1:0]       ev_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_out,
  input  logic                  sw_start,
  output logic                  sw_busy,
  output logic                  sw_done,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic [N_IN:0]         err_cnt,
  output logic                  err_any,
  output logic [N_IN-1:0]       first_err_idx
);

  localparam int TT_W = tt_w(N_IN);

  logic sample_bit;

`ifdef TTS_DUT_SYNC_EN
  // Two extra drive cycles cover the synchroniser latency.
  localparam int DRIVE_CYC = SETTLE + 2;

  logic [1:0] sync_q;

  // Two-flop synchroniser on the netlist response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], dut_out};
  end

  assign sample_bit = sync_q[1];
`else
  localparam int DRIVE_CYC = SETTLE;

  assign sample_bit = dut_out;
`endif

  localparam int                CNT_W    = cnt_w(DRIVE_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRIVE_CYC - 1);
  localparam logic [N_IN-1:0]   IDX_LAST = {N_IN{1'b1}};

  sweep_state_e    state_q, state_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic            err_any_q, err_any_d;
  logic [N_IN-1:0] first_err_q, first_err_d;
  logic            res_valid_q, res_valid_d;
  logic            res_out_q, res_out_d;

  logic ev_bit;
  logic sw_bit;
  logic ev_fire;

  tt_lut_mux #(.N_IN(N_IN)) u_ev_mux (
    .tt_i  (tt_q),
    .sel_i (ev_in),
    .bit_o (ev_bit)
  );

  tt_lut_mux #(.N_IN(N_IN)) u_sw_mux (
    .tt_i  (tt_q),
    .sel_i (idx_q),
    .bit_o (sw_bit)
  );

  assign sw_busy  = (state_q != IDLE);
  assign sw_done  = (state_q == DONE);
  assign ev_ready = !rst && !sw_busy && (!res_valid_q || res_ready);
  assign ev_fire  = ev_valid && ev_ready;

  assign res_valid     = res_valid_q;
  assign res_out       = res_out_q;
  assign dut_in        = idx_q;
  assign err_cnt       = err_cnt_q;
  assign err_any       = err_any_q;
  assign first_err_idx = first_err_q;

  // Eval result slot and table write; the eval mux reads the pre-write table.
  always_comb begin
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    tt_d        = tt_q;
    if (ev_fire) begin
      res_valid_d = 1'b1;
      res_out_d   = ev_bit;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    if (tt_wr && (state_q == IDLE)) begin
      tt_d = tt_wdata;
    end
  end

  // Sweep sequencer: drive each vector, let it settle, sample, tally mismatches.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    err_any_d   = err_any_q;
    first_err_d = first_err_q;
    case (state_q)
      IDLE: begin
        if (sw_start) begin
          state_d     = DRIVE;
          idx_d       = '0;
          cnt_d       = '0;
          err_cnt_d   = '0;
          err_any_d   = 1'b0;
          first_err_d = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      SAMPLE: begin
        if (sample_bit != sw_bit) begin
          err_cnt_d = err_cnt_q + (N_IN+1)'(1);
          if (!err_any_q) begin
            err_any_d   = 1'b1;
            first_err_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset restores the initial table and aborts any sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tt_q        <= TT_INIT;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
      err_any_q   <= 1'b0;
      first_err_q <= '0;
      res_valid_q <= 1'b0;
      res_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_any_q   <= err_any_d;
      first_err_q <= first_err_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
    end
  end

endmodule

// File: tb/tb_tt_sweep_eval.sv
// tb/tb_tt_sweep_eval.sv - self-checking bench for tt_sweep_eval
module tb_tt_sweep_eval;

  localparam int TT_W = 16;
`ifdef TTS_DUT_SYNC_EN
  localparam int DRIVE_C = 4;
`else
  localparam int DRIVE_C = 2;
`endif
  localparam int SWEEP_LEN = TT_W * (DRIVE_C + 1) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tt_wr = 1'b0;
  logic [15:0] tt_wdata = '0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [3:0]  ev_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_out;
  logic        sw_start = 1'b0;
  logic        sw_busy;
  logic        sw_done;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic [4:0]  err_cnt;
  logic        err_any;
  logic [3:0]  first_err_idx;

  logic [15:0] netlist_tt = 16'h09AF;
  logic [15:0] m_tt = 16'h09AF;
  int n_chk = 0;
  int n_fail = 0;

  tt_sweep_eval dut (
    .clk(clk), .rst(rst), .tt_wr(tt_wr), .tt_wdata(tt_wdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_in(ev_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .sw_start(sw_start), .sw_busy(sw_busy), .sw_done(sw_done),
    .dut_in(dut_in), .dut_out(dut_out), .err_cnt(err_cnt),
    .err_any(err_any), .first_err_idx(first_err_idx)
  );

  assign dut_out = netlist_tt[dut_in];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev_valid = 1'b1; ev_in = 4'd0; res_ready = 1'b1;
    #2;
    n_chk++; if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ev_ready got %b want 0", ev_ready); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_chk++; if (res_out !== 1'b0) begin n_fail++; $display("FAIL reset_res_out got %b want 0", res_out); end
    n_chk++; if (sw_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sw_busy got %b want 0", sw_busy); end
    n_chk++; if (sw_done !== 1'b0) begin n_fail++; $display("FAIL reset_sw_done got %b want 0", sw_done); end
    n_chk++; if (dut_in !== 4'd0) begin n_fail++; $display("FAIL reset_dut_in got %0d want 0", dut_in); end
    n_chk++; if (err_cnt !== 5'd0 || err_any !== 1'b0 || first_err_idx !== 4'd0) begin
      n_fail++; $display("FAIL reset_err got cnt=%0d any=%b first=%0d want 0/0/0", err_cnt, err_any, first_err_idx);
    end
    tick(); tick();
    n_chk++; if (ev_ready !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_held got ev_ready=%b res_valid=%b want 0/0", ev_ready, res_valid);
    end
    rst = 1'b0; ev_valid = 1'b0;
    tick();
  endtask

  task automatic test_eval_back_to_back();
    logic [3:0] vecs [4];
    logic       want [4];
    logic       exp_b;
    vecs = '{4'd0, 4'd4, 4'd8, 4'd12};
    want = '{1'b1, 1'b0, 1'b1, 1'b0};
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_valid = 1'b1; ev_in = vecs[i];
      #1;
      n_chk++; if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, ev_ready); end
      tick();
      n_chk++; if (res_valid !== 1'b1 || res_out !== want[i]) begin
        n_fail++; $display("FAIL b2b_result[%0d] got v=%b o=%b want v=1 o=%b", i, res_valid, res_out, want[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      ev_valid = 1'b1; ev_in = 4'($urandom);
      exp_b = m_tt[ev_in];
      tick();
      n_chk++; if (res_valid !== 1'b1 || res_out !== exp_b) begin
        n_fail++; $display("FAIL b2b_rand[%0d] got v=%b o=%b want v=1 o=%b", i, res_valid, res_out, exp_b);
      end
    end
    ev_valid = 1'b0;
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got res_valid=%b want 0", res_valid); end
  endtask

  task automatic test_backpressure();
    logic q[$];
    logic held, prev_out, exp_rdy;
    int   n_acc, n_cons;
    n_acc = 0; n_cons = 0;
    for (int i = 0; i < 300; i++) begin
      ev_valid  = ($urandom_range(0, 3) != 0);
      ev_in     = 4'($urandom);
      res_ready = (i >= 5 && i < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() == 0) || res_ready;
      n_chk++; if (ev_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want %b", i, ev_ready, exp_rdy); end
      if (res_valid && res_ready) begin
        n_chk++;
        if (q.size() == 0) begin n_fail++; $display("FAIL bp_dup[%0d] got result with nothing pending want none", i); end
        else begin
          if (res_out !== q[0]) begin n_fail++; $display("FAIL bp_data[%0d] got %b want %b", i, res_out, q[0]); end
          void'(q.pop_front());
          n_cons++;
        end
      end
      held = res_valid && !res_ready;
      prev_out = res_out;
      if (ev_valid && ev_ready) begin q.push_back(m_tt[ev_in]); n_acc++; end
      tick();
      n_chk++; if (res_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL bp_valid[%0d] got %b want %b", i, res_valid, q.size() != 0);
      end
      if (held) begin
        n_chk++; if (res_valid !== 1'b1 || res_out !== prev_out) begin
          n_fail++; $display("FAIL bp_hold[%0d] got v=%b o=%b want v=1 o=%b", i, res_valid, res_out, prev_out);
        end
      end
    end
    ev_valid = 1'b0; res_ready = 1'b1;
    if (res_valid && q.size() != 0) begin void'(q.pop_front()); n_cons++; end
    tick();
    n_chk++; if (n_acc !== n_cons || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_count got acc=%0d cons=%0d valid=%b want equal/0", n_acc, n_cons, res_valid);
    end
  endtask

  task automatic run_sweep(input logic [15:0] netlist, input bit poke, input string name);
    int cyc, done_cyc, ndone, exp_cnt, exp_first;
    bit exp_any;
    exp_cnt = 0; exp_first = 0; exp_any = 1'b0;
    for (int v = 0; v < TT_W; v++) begin
      if (netlist[v] != m_tt[v]) begin
        if (!exp_any) exp_first = v;
        exp_any = 1'b1;
        exp_cnt++;
      end
    end
    netlist_tt = netlist;
    sw_start = 1'b1;
    tick();
    sw_start = 1'b0;
    cyc = 1; done_cyc = 0; ndone = 0;
    while (cyc <= SWEEP_LEN + 4) begin
      if (sw_done) begin ndone++; if (done_cyc == 0) done_cyc = cyc; end
      if (cyc <= SWEEP_LEN) begin
        n_chk++; if (sw_busy !== 1'b1 || ev_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s_busy[%0d] got busy=%b ev_ready=%b want 1/0", name, cyc, sw_busy, ev_ready);
        end
      end
      if (poke && cyc == 10) begin tt_wr = 1'b1; tt_wdata = 16'hFFFF; sw_start = 1'b1; end
      else begin tt_wr = 1'b0; sw_start = 1'b0; end
      tick();
      cyc++;
    end
    n_chk++; if (done_cyc !== SWEEP_LEN || ndone !== 1) begin
      n_fail++; $display("FAIL %s_len got done at %0d (x%0d) want %0d (x1)", name, done_cyc, ndone, SWEEP_LEN);
    end
    n_chk++; if (err_cnt !== 5'(exp_cnt) || err_any !== exp_any || first_err_idx !== 4'(exp_first)) begin
      n_fail++; $display("FAIL %s_err got cnt=%0d any=%b first=%0d want %0d/%b/%0d",
                         name, err_cnt, err_any, first_err_idx, exp_cnt, exp_any, exp_first);
    end
    n_chk++; if (dut_in !== 4'hF || sw_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_end got dut_in=%0d busy=%b want 15/0", name, dut_in, sw_busy);
    end
  endtask

  task automatic test_sweep_exact();
    res_ready = 1'b0; ev_valid = 1'b1; ev_in = 4'd8;
    tick();
    ev_valid = 1'b0;
    run_sweep(16'h09AF, 1'b0, "sw_exact");
    n_chk++; if (res_valid !== 1'b1 || res_out !== 1'b1) begin
      n_fail++; $display("FAIL sw_pending got v=%b o=%b want v=1 o=1", res_valid, res_out);
    end
    res_ready = 1'b1;
    tick();
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL sw_pending_drain got %b want 0", res_valid); end
  endtask

  task automatic test_sweep_errors();
    run_sweep(16'h09AF ^ 16'h0420, 1'b0, "sw_err");
    n_chk++; if (err_cnt !== 5'd2 || first_err_idx !== 4'd5 || err_any !== 1'b1) begin
      n_fail++; $display("FAIL sw_err_fixed got cnt=%0d first=%0d any=%b want 2/5/1", err_cnt, first_err_idx, err_any);
    end
    for (int i = 0; i < 3; i++) run_sweep(m_tt ^ 16'($urandom), 1'b0, "sw_rand");
  endtask

  task automatic test_tt_write();
    run_sweep(m_tt, 1'b1, "sw_wr_busy");
    res_ready = 1'b1; ev_valid = 1'b1; ev_in = 4'd4; tt_wr = 1'b1; tt_wdata = 16'hFFFF;
    tick();
    tt_wr = 1'b0;
    n_chk++; if (res_out !== 1'b0) begin n_fail++; $display("FAIL wr_old_table got %b want 0", res_out); end
    m_tt = 16'hFFFF;
    tick();
    ev_valid = 1'b0;
    n_chk++; if (res_out !== 1'b1) begin n_fail++; $display("FAIL wr_new_table got %b want 1", res_out); end
    tick();
    run_sweep(m_tt ^ 16'($urandom), 1'b0, "sw_after_wr");
  endtask

  task automatic test_reset_mid_sweep();
    int guard;
    bit saw_done;
    netlist_tt = m_tt ^ 16'h0006;
    sw_start = 1'b1;
    tick();
    sw_start = 1'b0;
    guard = 0;
    while (dut_in !== 4'd7 && guard < 200) begin tick(); guard++; end
    n_chk++; if (guard >= 200) begin n_fail++; $display("FAIL rst_wait got no dut_in=7 want it within 200 cycles"); end
    n_chk++; if (err_cnt !== 5'd2) begin n_fail++; $display("FAIL rst_pre_err got %0d want 2", err_cnt); end
    rst = 1'b1;
    #1;
    n_chk++; if (sw_busy !== 1'b0 || err_cnt !== 5'd0 || sw_done !== 1'b0 || dut_in !== 4'd0) begin
      n_fail++; $display("FAIL rst_abort got busy=%b cnt=%0d done=%b dut_in=%0d want 0/0/0/0", sw_busy, err_cnt, sw_done, dut_in);
    end
    saw_done = 1'b0;
    repeat (3) begin tick(); if (sw_done) saw_done = 1'b1; end
    rst = 1'b0;
    m_tt = 16'h09AF;
    repeat (SWEEP_LEN) begin tick(); if (sw_done) saw_done = 1'b1; end
    n_chk++; if (saw_done) begin n_fail++; $display("FAIL rst_no_done got sw_done=1 want none"); end
    run_sweep(16'h09AF, 1'b0, "sw_post_rst");
    run_sweep(16'h09AF ^ 16'($urandom), 1'b0, "sw_post_rst_rand");
  endtask

  initial begin
    test_reset();
    test_eval_back_to_back();
    test_backpressure();
    test_sweep_exact();
    test_sweep_errors();
    test_tt_write();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
